ssd_scan_arbiter: RTL and testbench
===================================

# ssd_scan_arbiter

Time-multiplexed scan controller for the 4-digit, common-anode seven-segment display, shared between two result sources (adder and multiplier readout). It arbitrates display ownership with a req/gnt handshake, snapshots the owner's 16-bit value once per frame, and drives per-digit anode strobes with an inter-digit blanking gap to suppress ghosting. Its outputs connect directly to the board display pins.

## Interface
- DIGIT_CYCLES, 65536: clock cycles per digit slot, blank gap included; ≥ 2.
- BLANK_CYCLES, 1024: cycles at the end of each slot with all anodes off; 0 ≤ BLANK_CYCLES < DIGIT_CYCLES.
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 wants the display; held high while ownership is wanted.
- val0  in  16  requester 0 value, four hex nibbles.
- req1  in  1  requester 1 request.
- val1  in  16  requester 1 value.
- gnt0  out  1  requester 0 owns the display.
- gnt1  out  1  requester 1 owns the display.
- en_mask  in  4  per-digit enable; bit i low blanks digit i.
- seg  out  7  segments abcdefg, active-low.
- an  out  4  anodes an[3:0], active-low; at most one low at any time.

## Operation
- Scan sequencer: digit index d (0..3) and slot counter cnt (0..DIGIT_CYCLES-1).
  - SHOW phase: cnt < DIGIT_CYCLES-BLANK_CYCLES.
  - BLANK phase: remaining cycles of the slot.
  - On the last cycle of a slot: cnt→0, d→d+1 mod 4.
- Frame = digits 0..3 in order. Frame boundary = clock edge ending digit 3's slot.
- Arbitration is evaluated only at frame boundaries. Owner state is NONE, OWN0 or OWN1.
  - NONE: grant the single requester if one is high. If both are high, grant the requester opposite to the last owner (requester 0 after reset).
  - OWNx with reqx high: keep ownership. Ownership never changes mid-frame.
  - OWNx with reqx low: release. The other requester is granted at the same boundary if its req is high, otherwise go to NONE.
- Snapshot: at each boundary, the new owner's val is latched into a 16-bit frame register. Changes to val mid-frame are invisible until the next boundary. In NONE the register is unused.
- Digit i shows frame_reg[4i+3:4i] on an[i].
- Hex encoding, abcdefg:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, B=1100000, C=0110001, D=1000010, E=0110000, F=0111000
- an[d] is low only during SHOW, while owner ≠ NONE and en_mask[d]=1. Otherwise an=1111 and seg=1111111.
- en_mask is sampled every cycle (no snapshot).

## Timing
- Reset (rst low, asynchronous, effective immediately, including mid-frame):
  - an=1111, seg=1111111, gnt0=gnt1=0
  - owner NONE, last-owner=1, d=0, cnt=0, frame_reg=0
- After rst deasserts, the first frame boundary is DIGIT_CYCLES*4 cycles later. Requests are not granted before then.
- All outputs are registered.
  - gnt changes on the boundary edge.
  - The snapshot value drives seg/an from that same edge, i.e. in the first SHOW cycle of digit 0.
- Grant latency: from req rise to gnt rise is 1 to 4*DIGIT_CYCLES cycles (next boundary).
- Release latency: gnt stays high until the boundary after req falls, even if req falls on the boundary cycle itself. req is sampled at the boundary edge.
- A requester that drops and raises req between boundaries is seen as continuously requesting.
- seg changes only when an is 1111 (BLANK or cnt=0 edge) or on the same edge an changes. No segment glitch is visible on a lit anode.
- BLANK_CYCLES=0: no blank phase; an steps directly from one digit to the next.
- Counters wrap: cnt at DIGIT_CYCLES-1 →0; d at 3 →0.

## Test plan
All scenarios use DIGIT_CYCLES=8, BLANK_CYCLES=2.
- Reset: hold rst low, drive req0=1 → an=1111, seg=1111111, gnt=00. Release rst → gnt0 rises exactly 32 cycles later.
- Single owner display: req0=1, val0=16'h8A3F, en_mask=1111.
  - Cycles 0-5: an=1110, seg=0111000 (F). Cycles 6-7: an=1111.
  - Then an=1101, seg=0000110 (3), and so on.
  - an=0111 shows seg=0000000 (8).
- Simultaneous requests from NONE after reset: both req high → gnt0. Drop req0 → gnt0 falls and gnt1 rises on the same boundary edge; val1 is displayed from that edge.
- Snapshot: while owned, change val0 from 16'h1234 to 16'h5678 mid-frame → remaining digits still show 1234; 5678 appears from the next frame's digit 0.
- en_mask=1010 → an never takes values 1110 or 1011. Digits 1 and 3 light normally.
- Mid-frame async reset during digit 2 SHOW → an=1111 and gnt=00 immediately, without waiting for a clock edge. After release, scanning restarts at digit 0, cnt=0.

Source files
------------

// File: rtl/ssd_scan_arbiter.sv
// ssd_scan_arbiter: four-digit common-anode seven-segment scan controller
// shared between two requesters. Ownership is arbitrated only at frame
// boundaries. The owner's value is snapshotted once per frame. Each digit
// slot ends with an all-anodes-off gap to suppress ghosting.
//
// Ports
//   clk      system clock
//   rst      asynchronous active-low reset
//   req0/1   ownership requests, held high while wanted
//   val0/1   16-bit values, four hex nibbles (digit i = bits 4i+3:4i)
//   gnt0/1   registered ownership grants
//   en_mask  per-digit enable, sampled every cycle
//   seg      segments abcdefg, active-low, registered
//   an       anodes an[3:0], active-low, registered, at most one low
module ssd_scan_arbiter #(
  parameter int unsigned DIGIT_CYCLES = 65536,
  parameter int unsigned BLANK_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [15:0] val0,
  input  logic        req1,
  input  logic [15:0] val1,
  output logic        gnt0,
  output logic        gnt1,
  input  logic [3:0]  en_mask,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int unsigned CW          = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int unsigned SHOW_CYCLES = DIGIT_CYCLES - BLANK_CYCLES;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);

  typedef enum logic [1:0] {
    NONE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_t;

  owner_t        owner_q, owner_d;
  logic          last_q, last_d;       // last owner: 0 = requester 0, 1 = requester 1
  logic [1:0]    d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   frame_q, frame_d;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic          gnt0_d, gnt1_d;
  logic          slot_end, boundary, show, lit;
  logic [3:0]    nib;

  // Hex nibble to active-low abcdefg pattern
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q <= NONE;
      last_q  <= 1'b1;
      d_q     <= 2'd0;
      cnt_q   <= '0;
      frame_q <= 16'h0000;
      an      <= 4'hF;
      seg     <= 7'h7F;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      an      <= an_d;
      seg     <= seg_d;
      gnt0    <= gnt0_d;
      gnt1    <= gnt1_d;
    end
  end

  // Scan sequencing, arbitration at frame boundary, next output values
  always_comb begin
    owner_d  = owner_q;
    last_d   = last_q;
    frame_d  = frame_q;
    cnt_d    = cnt_q + CW'(1);
    d_d      = d_q;
    slot_end = (cnt_q == CNT_LAST);
    boundary = slot_end && (d_q == 2'd3);

    if (slot_end) begin
      cnt_d = '0;
      d_d   = d_q + 2'd1;
    end

    if (boundary) begin
      case (owner_q)
        NONE: begin
          if (req0 && req1) owner_d = last_q ? OWN0 : OWN1;
          else if (req0)    owner_d = OWN0;
          else if (req1)    owner_d = OWN1;
          else              owner_d = NONE;
        end
        OWN0: begin
          if (req0)      owner_d = OWN0;
          else if (req1) owner_d = OWN1;
          else           owner_d = NONE;
        end
        OWN1: begin
          if (req1)      owner_d = OWN1;
          else if (req0) owner_d = OWN0;
          else           owner_d = NONE;
        end
        default: owner_d = NONE;
      endcase

      if (owner_d == OWN0) begin
        frame_d = val0;
        last_d  = 1'b0;
      end else if (owner_d == OWN1) begin
        frame_d = val1;
        last_d  = 1'b1;
      end
    end

    // Outputs are computed from next state so seg/an/gnt move together on one edge
    show   = (32'(cnt_d) < SHOW_CYCLES);
    lit    = show && (owner_d != NONE) && en_mask[d_d];
    nib    = 4'(frame_d >> {d_d, 2'b00});
    an_d   = lit ? ~(4'b0001 << d_d) : 4'hF;
    seg_d  = lit ? hex7(nib) : 7'h7F;
    gnt0_d = (owner_d == OWN0);
    gnt1_d = (owner_d == OWN1);
  end

endmodule

// File: tb/tb_ssd_scan_arbiter.sv
// Directed bench for ssd_scan_arbiter with DIGIT_CYCLES=8, BLANK_CYCLES=2.
module tb_ssd_scan_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0;
  logic [15:0] val0 = 16'h0000;
  logic        req1 = 1'b0;
  logic [15:0] val1 = 16'h0000;
  logic        gnt0, gnt1;
  logic [3:0]  en_mask = 4'hF;
  logic [6:0]  seg;
  logic [3:0]  an;

  int n_cmp = 0;
  int n_bad = 0;

  ssd_scan_arbiter #(.DIGIT_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .val0(val0), .req1(req1), .val1(val1),
    .gnt0(gnt0), .gnt1(gnt1), .en_mask(en_mask),
    .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n active edges, then sample 1 time unit later
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Count edges after reset release until a grant appears (bounded)
  task automatic wait_grant(input string tag, input int exp_edges);
    int lat;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (gnt0 || gnt1) begin
        lat = i;
        break;
      end
    end
    chk(tag, 32'(lat), 32'(exp_edges));
  endtask

  int         tc[7] = '{0, 5, 6, 8, 16, 24, 31};
  logic [3:0] ta[7] = '{4'hE, 4'hE, 4'hF, 4'hD, 4'hB, 4'h7, 4'hF};
  logic [6:0] ts[7] = '{7'b0111000, 7'b0111000, 7'h7F, 7'b0000110,
                        7'b0001000, 7'b0000000, 7'h7F};

  initial begin
    bit bad_an, saw1, saw3, found;

    // Reset held with a pending request
    req0 = 1'b1;
    val0 = 16'h8A3F;
    step(3);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_gnt", 32'({gnt1, gnt0}), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    wait_grant("first_grant_lat", 32);
    chk("first_gnt", 32'({gnt1, gnt0}), 32'h1);

    // Single owner scan of 8A3F
    for (int c = 0; c < 32; c++) begin
      for (int j = 0; j < 7; j++) begin
        if (tc[j] == c) begin
          chk($sformatf("scan_an_c%0d", c), 32'(an), 32'(ta[j]));
          chk($sformatf("scan_seg_c%0d", c), 32'(seg), 32'(ts[j]));
        end
      end
      step(1);
    end

    // Simultaneous requests from NONE, then handover
    req1 = 1'b1;
    val1 = 16'hC0DE;
    do_reset();
    wait_grant("both_grant_lat", 32);
    chk("both_gnt", 32'({gnt1, gnt0}), 32'h1);
    step(10);
    req0 = 1'b0;
    step(21);
    chk("handover_pre", 32'({gnt1, gnt0}), 32'h1);
    step(1);
    chk("handover_gnt", 32'({gnt1, gnt0}), 32'h2);
    chk("handover_an", 32'(an), 32'hE);
    chk("handover_seg", 32'(seg), 32'b0110000);

    // Snapshot: mid-frame value change is deferred to next frame
    req1 = 1'b0;
    req0 = 1'b1;
    val0 = 16'h1234;
    do_reset();
    wait_grant("snap_grant_lat", 32);
    chk("snap_d0", 32'(seg), 32'b1001100);
    step(10);
    val0 = 16'h5678;
    step(6);
    chk("snap_d2_an", 32'(an), 32'hB);
    chk("snap_d2_seg", 32'(seg), 32'b0010010);
    step(8);
    chk("snap_d3_seg", 32'(seg), 32'b1001111);
    step(8);
    chk("snap_new_an", 32'(an), 32'hE);
    chk("snap_new_seg", 32'(seg), 32'b0000000);
    step(8);
    chk("snap_new_d1", 32'(seg), 32'b0001111);

    // Digit enable mask 1010
    en_mask = 4'b1010;
    step(1);
    bad_an = 1'b0;
    saw1   = 1'b0;
    saw3   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (an == 4'hE || an == 4'hB) bad_an = 1'b1;
      if (an == 4'hD) saw1 = 1'b1;
      if (an == 4'h7) saw3 = 1'b1;
      step(1);
    end
    chk("mask_no_d0_d2", 32'(bad_an), 32'h0);
    chk("mask_d1_lit", 32'(saw1), 32'h1);
    chk("mask_d3_lit", 32'(saw3), 32'h1);

    // Asynchronous reset during digit 2 SHOW
    en_mask = 4'hF;
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step(1);
      if (an == 4'hB) begin
        found = 1'b1;
        break;
      end
    end
    chk("find_d2", 32'(found), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_an", 32'(an), 32'hF);
    chk("async_seg", 32'(seg), 32'h7F);
    chk("async_gnt", 32'({gnt1, gnt0}), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    wait_grant("restart_grant_lat", 32);
    chk("restart_an", 32'(an), 32'hE);
    chk("restart_seg", 32'(seg), 32'b0000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
